// File: rtl/vend_credit_ctrl_if.sv
// Coin, vend and hopper signal bundle between the switch front end and vend_credit_ctrl.
// master drives coins/cancel/acks, slave (the controller) drives requests, pulses and status.
interface vend_credit_ctrl_if #(
  parameter int CREDIT_W = 4
);
  logic                quarter;
  logic                halfDollar;
  logic                dollar;
  logic                cancel;
  logic                vend_ack;
  logic                hopper_rdy;
  logic                vend_req;
  logic                coin_h_out;
  logic                coin_q_out;
  logic                reject;
  logic                fault;
  logic [CREDIT_W-1:0] credit;
  logic [1:0]          state;

  modport master (
    output quarter, halfDollar, dollar, cancel, vend_ack, hopper_rdy,
    input  vend_req, coin_h_out, coin_q_out, reject, fault, credit, state
  );

  modport slave (
    input  quarter, halfDollar, dollar, cancel, vend_ack, hopper_rdy,
    output vend_req, coin_h_out, coin_q_out, reject, fault, credit, state
  );
endinterface

// File: rtl/vend_credit_ctrl.sv
// Guffin vending credit/vend/change sequencer; VEND_TIMEOUT_EN adds a VEND wait limit with refund.
// All outputs registered (coin effect visible next cycle); vend waits on vend_ack, change stalls on hopper_rdy.
module vend_credit_ctrl #(
  parameter int PRICE_Q     = 6,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              CLK,
  input  logic              RES,
  vend_credit_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE      = CREDIT_W'(PRICE_Q);
  localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_req_q, vend_req_d;
  logic                coin_h_q, coin_h_d;
  logic                coin_q_q, coin_q_d;
  logic                reject_q, reject_d;
  logic                fault_q, fault_d;

  logic [2:0]          coin_vec;
  logic                coin_any;
  logic                coin_multi;
  logic                coin_ok;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   credit_sum;
  logic                tmo_hit;

  assign coin_vec   = {bus.dollar, bus.halfDollar, bus.quarter};
  assign coin_any   = |coin_vec;
  // Clearing the lowest set bit leaves something only when two or more coins arrived together.
  assign coin_multi = (coin_vec & (coin_vec - 3'd1)) != 3'd0;

  always_comb begin
    coin_val = '0;
    case (coin_vec)
      3'b001:  coin_val = (CREDIT_W+1)'(1);
      3'b010:  coin_val = (CREDIT_W+1)'(2);
      3'b100:  coin_val = (CREDIT_W+1)'(4);
      default: coin_val = '0;
    endcase
  end

  assign credit_sum = {1'b0, credit_q} + coin_val;
  assign coin_ok    = coin_any && !coin_multi && (credit_sum <= CREDIT_MAX);

`ifdef VEND_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit   = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  // Zero on VEND entry, then counts each cycle spent waiting for the ack.
  assign tmo_cnt_d = (state_q == VEND && state_d == VEND) ? tmo_cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    vend_req_d = 1'b0;
    coin_h_d   = 1'b0;
    coin_q_d   = 1'b0;
    reject_d   = 1'b0;
    fault_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (coin_ok) begin
          credit_d = credit_sum[CREDIT_W-1:0];
          state_d  = COLLECT;
        end else begin
          reject_d = coin_any;
        end
      end
      COLLECT: begin
        if (coin_ok) begin
          credit_d = credit_sum[CREDIT_W-1:0];
        end else begin
          reject_d = coin_any;
        end
        // Reaching the price beats a cancel seen in the same cycle.
        if (credit_q >= PRICE) begin
          state_d = VEND;
        end else if (bus.cancel) begin
          state_d = CHANGE;
        end
      end
      VEND: begin
        reject_d = coin_any;
        if (bus.vend_ack) begin
          credit_d = credit_q - PRICE;
          state_d  = (credit_d != '0) ? CHANGE : IDLE;
        end else if (tmo_hit) begin
          fault_d = 1'b1;
          state_d = CHANGE;
        end
      end
      CHANGE: begin
        reject_d = coin_any;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (bus.hopper_rdy) begin
          if (credit_q >= CREDIT_W'(2)) begin
            coin_h_d = 1'b1;
            credit_d = credit_q - CREDIT_W'(2);
          end else begin
            coin_q_d = 1'b1;
            credit_d = '0;
          end
          if (credit_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    vend_req_d = (state_d == VEND);
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      vend_req_q <= 1'b0;
      coin_h_q   <= 1'b0;
      coin_q_q   <= 1'b0;
      reject_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      vend_req_q <= vend_req_d;
      coin_h_q   <= coin_h_d;
      coin_q_q   <= coin_q_d;
      reject_q   <= reject_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.credit     = credit_q;
  assign bus.vend_req   = vend_req_q;
  assign bus.coin_h_out = coin_h_q;
  assign bus.coin_q_out = coin_q_q;
  assign bus.reject     = reject_q;
  assign bus.fault      = fault_q;

endmodule
